// File: rtl/nrx_lanes.sv
// Multi-lane serial NoC receiver: deserialises LANES-wide beats into DATA_W words and queues them in a DEPTH-entry FIFO.
// Optional even-parity beat per frame when NRX_PARITY_EN is defined (adds output parity_err).
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif

module nrx_lanes #(
  parameter int    ID     = 0,
  parameter string DIR    = "west",
  parameter int    LANES  = 1,
  parameter int    DATA_W = `PAYLOAD_SIZE + `ADDR_BITS,
  parameter int    DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANES-1:0]  serial_in,
  output logic              channel_busy,
  output logic              valid,
  input  logic              item_read,
  output logic [DATA_W-1:0] parallel_out,
  output logic              overflow,
  output logic              rx_active
`ifdef NRX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned BEATS   = (DATA_W + LANES - 1) / LANES;
  localparam int unsigned SHIFT_W = BEATS * LANES;
  localparam int unsigned BCNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BUSY_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  state_t              r_state, w_state_next;
  logic [BCNT_W-1:0]   r_beat;
  logic [SHIFT_W-1:0]  w_asm;
  logic [DATA_W-1:0]   w_word;
  logic                w_last_beat;
  logic                w_done;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [CNT_W-1:0]    r_count, w_count_next, w_keep;
  logic [DATA_W-1:0]   r_head, w_head_next;
  logic                r_valid, r_ovf;
  logic                w_pop, w_full, w_push, w_drop;

  assign w_last_beat = (r_state == S_DATA) && (r_beat == BCNT_W'(BEATS - 1));

  // Beat assembly: each beat enters at the top, so beat 0 ends up in the low bits.
`ifdef NRX_PARITY_EN
  logic [SHIFT_W-1:0] r_hold;
  logic               r_perr;
  logic               w_par_beat, w_par_ok;

  if (BEATS == 1) begin : g_asm
    assign w_asm = serial_in;
  end else begin : g_asm
    assign w_asm = {serial_in, r_hold[SHIFT_W-1:LANES]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_perr <= 1'b0;
    end else begin
      if (r_state == S_DATA) r_hold <= w_asm;
      r_perr <= w_par_beat && !w_par_ok;
    end
  end

  assign w_word     = r_hold[DATA_W-1:0];
  assign w_par_beat = (r_state == S_PARITY);
  assign w_par_ok   = ((^w_word) == serial_in[0]);
  assign w_done     = w_par_beat && w_par_ok;
  assign parity_err = r_perr;
`else
  if (BEATS == 1) begin : g_asm
    assign w_asm = serial_in;
  end else begin : g_asm
    logic [SHIFT_W-LANES-1:0] r_hold;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_hold <= '0;
      else if (r_state == S_DATA) r_hold <= w_asm[SHIFT_W-1:LANES];
    end
    assign w_asm = {serial_in, r_hold};
  end

  assign w_word = w_asm[DATA_W-1:0];
  assign w_done = w_last_beat;
`endif

  // FSM state and beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= (r_state == S_DATA && !w_last_beat) ? r_beat + BCNT_W'(1) : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (serial_in[0]) w_state_next = S_DATA;
`ifdef NRX_PARITY_EN
      S_DATA:   if (w_last_beat) w_state_next = S_PARITY;
      S_PARITY: w_state_next = S_IDLE;
`else
      S_DATA:   if (w_last_beat) w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // A completed frame is dropped only when the buffer is full and nothing leaves this cycle.
  assign w_pop        = item_read && r_valid;
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_push       = w_done && (!w_full || w_pop);
  assign w_drop       = w_done && w_full && !w_pop;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
  assign w_keep       = r_count - CNT_W'(w_pop);

  always_comb begin
    w_head_next = '0;
    if (w_keep != '0) w_head_next = r_mem[w_rd_next];
    else if (w_push)  w_head_next = w_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
      r_valid  <= (w_count_next != '0);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && w_drop)
      $display("nrx_lanes %0d %s: overflow, dropped word %h", ID, DIR, w_word);
  end
`endif

  assign rx_active    = (r_state != S_IDLE);
  assign channel_busy = (BUSY_W'(r_count) + BUSY_W'(rx_active)) >= BUSY_W'(DEPTH);
  assign valid        = r_valid;
  assign parallel_out = r_head;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_nrx_lanes.sv
// Self-checking bench for nrx_lanes: directed frames plus randomized traffic against a queue-based model.
module tb_nrx_lanes;

  localparam int D4 = 4;

  typedef struct packed {
    logic [3:0]  lanes;
    logic        start;
    logic        last;
    logic        bad;
    logic [15:0] word;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  serial4;
  logic        rd4, busy4, valid4, ovf4, rx4;
  logic [15:0] pout4;
  logic [0:0]  serial1;
  logic        rd1, busy1, valid1, ovf1, rx1;
  logic [15:0] pout1;
`ifdef NRX_PARITY_EN
  logic        perr4, perr1;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       beat_q[$];
  logic [15:0] mq[$];
  logic        m_rx, m_ovf, m_perr;

  always #5 clk = ~clk;

  nrx_lanes #(.ID(3), .DIR("north"), .LANES(4), .DATA_W(16), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .serial_in(serial4), .channel_busy(busy4), .valid(valid4),
    .item_read(rd4), .parallel_out(pout4), .overflow(ovf4), .rx_active(rx4)
`ifdef NRX_PARITY_EN
    , .parity_err(perr4)
`endif
  );

  nrx_lanes #(.ID(7), .DIR("east"), .LANES(1), .DATA_W(16), .DEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .serial_in(serial1), .channel_busy(busy1), .valid(valid1),
    .item_read(rd1), .parallel_out(pout1), .overflow(ovf1), .rx_active(rx1)
`ifdef NRX_PARITY_EN
    , .parity_err(perr1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue one frame for the 4-lane receiver: start beat, nibble beats LSB first, optional parity beat.
  task automatic start_frame(input logic [15:0] w, input logic bad);
    beat_t b;
    b = '0; b.start = 1'b1; b.lanes = 4'($urandom) | 4'h1; b.word = w;
    beat_q.push_back(b);
    for (int k = 0; k < 4; k++) begin
      b = '0; b.lanes = w[k*4 +: 4]; b.word = w;
`ifndef NRX_PARITY_EN
      b.last = (k == 3);
`endif
      beat_q.push_back(b);
    end
`ifdef NRX_PARITY_EN
    b = '0; b.lanes = (4'($urandom) & 4'hE) | {3'b000, (^w) ^ bad};
    b.last = 1'b1; b.bad = bad; b.word = w;
    beat_q.push_back(b);
`else
    if (bad) $display("note: parity not built, bad flag ignored");
`endif
  endtask

  // One clock for the 4-lane receiver: drive, update the model at the edge, compare at the falling edge.
  task automatic tick(input logic rd);
    beat_t b;
    logic  full, pop;
    if (beat_q.size() != 0) b = beat_q.pop_front();
    else begin b = '0; b.lanes = 4'($urandom) & 4'hE; end
    serial4 = b.lanes;
    rd4     = rd;
    @(posedge clk);
    full   = (mq.size() == D4);
    pop    = rd && (mq.size() != 0);
    m_perr = 1'b0;
    if (b.start) m_rx = 1'b1;
    if (pop) void'(mq.pop_front());
    if (b.last) begin
      m_rx = 1'b0;
      if (b.bad)             m_perr = 1'b1;
      else if (full && !pop) m_ovf  = 1'b1;
      else                   mq.push_back(b.word);
    end
    @(negedge clk);
    chk("valid", 32'(valid4), 32'(mq.size() != 0));
    chk("data",  32'(pout4), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("busy",  32'(busy4), 32'((mq.size() + int'(m_rx)) >= D4));
    chk("ovf",   32'(ovf4),  32'(m_ovf));
    chk("rx",    32'(rx4),   32'(m_rx));
`ifdef NRX_PARITY_EN
    chk("perr",  32'(perr4), 32'(m_perr));
`endif
  endtask

  task automatic flush(input logic rd_on_last);
    while (beat_q.size() != 0) tick(rd_on_last && (beat_q.size() == 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) tick(1'b1);
  endtask

  task automatic model_reset();
    mq.delete(); beat_q.delete();
    m_rx = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  task automatic lane1_frame(input logic [15:0] w, input logic bad);
    serial1 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("l1_rx", 32'(rx1), 32'd1);
    for (int k = 0; k < 16; k++) begin
      serial1 = w[k];
      @(posedge clk); @(negedge clk);
`ifdef NRX_PARITY_EN
      chk("l1_early", 32'(valid1), 32'd0);
`else
      if (k < 15) chk("l1_early", 32'(valid1), 32'd0);
`endif
    end
`ifdef NRX_PARITY_EN
    serial1 = (^w) ^ bad;
    @(posedge clk); @(negedge clk);
    chk("l1_perr", 32'(perr1), 32'(bad));
`endif
    serial1 = 1'b0;
    chk("l1_valid", 32'(valid1), 32'(!bad));
    chk("l1_data",  32'(pout1), bad ? 32'd0 : 32'(w));
    rd1 = 1'b1;
    @(posedge clk); @(negedge clk);
    rd1 = 1'b0;
    chk("l1_pop_valid", 32'(valid1), 32'd0);
    chk("l1_pop_data",  32'(pout1), 32'd0);
    chk("l1_idle_rx",   32'(rx1), 32'd0);
`ifdef NRX_PARITY_EN
    chk("l1_perr_pulse", 32'(perr1), 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] w;
    logic        bad;
    reset = 1'b0; serial4 = '0; rd4 = 1'b0; serial1 = '0; rd1 = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(valid4), 32'd0);
    chk("rst_data",  32'(pout4),  32'd0);
    chk("rst_busy",  32'(busy4),  32'd0);
    chk("rst_ovf",   32'(ovf4),   32'd0);
    chk("rst_rx",    32'(rx4),    32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Single frame 0x1234, then pop it
    start_frame(16'h1234, 1'b0);
    flush(1'b0);
    chk("single_word", 32'(pout4), 32'h1234);
    tick(1'b1);
    tick(1'b0);

    // Back-to-back fill, protocol-violating 5th frame, then a pop that coincides with a push at full
    for (int i = 1; i <= 4; i++) start_frame(16'(i), 1'b0);
    flush(1'b0);
    chk("fill_busy", 32'(busy4), 32'd1);
    start_frame(16'h0005, 1'b0);
    flush(1'b0);
    chk("viol_ovf",  32'(ovf4),  32'd1);
    chk("viol_head", 32'(pout4), 32'h0001);
    start_frame(16'h0006, 1'b0);
    flush(1'b1);
    drain();

    // Three words held, fourth completes with a same-cycle pop
    for (int i = 0; i < 3; i++) start_frame(16'h00A0 + 16'(i), 1'b0);
    flush(1'b0);
    start_frame(16'h00A3, 1'b0);
    flush(1'b1);
    chk("pop_push_head", 32'(pout4), 32'h00A1);
    drain();

    // Reset in the middle of a frame
    start_frame(16'h5555, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 32'(valid4), 32'd0);
    chk("mid_rst_rx",    32'(rx4),    32'd0);
    chk("mid_rst_busy",  32'(busy4),  32'd0);
    chk("mid_rst_ovf",   32'(ovf4),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_frame(16'hBEEF, 1'b0);
    flush(1'b0);
    chk("beef_word", 32'(pout4), 32'hBEEF);
    drain();

    // Single-lane receiver
    serial4 = '0; rd4 = 1'b0;
    lane1_frame(16'hA5C3, 1'b0);
`ifdef NRX_PARITY_EN
    lane1_frame(16'h3C5A, 1'b1);
    start_frame(16'h0F0F, 1'b1);
    flush(1'b0);
`endif

    // Randomized traffic, honouring channel_busy
    for (int c = 0; c < 600; c++) begin
      if (beat_q.size() == 0 && mq.size() < D4 && ($urandom_range(0, 2) == 0)) begin
        w = 16'($urandom);
`ifdef NRX_PARITY_EN
        bad = ($urandom_range(0, 4) == 0);
`else
        bad = 1'b0;
`endif
        start_frame(w, bad);
      end
      tick(($urandom_range(0, 2) == 0));
    end
    flush(1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nrx_lanes.md
Name: nrx_lanes

Overview:
- Parametrised single-clock successor to the NoC serial receive path.
- Deserialises flits arriving on LANES parallel serial wires into `PAYLOAD_SIZE+`ADDR_BITS-wide words and queues them in a DEPTH-entry output buffer.
- Exerts channel_busy back-pressure on the upstream tx and presents words to the router through a valid/item_read handshake.
- Sits at each router port, one instance per direction.

Parameters:
- ID, 0: router/port identifier, used only in simulation messages.
- DIR, "west": port direction string, used only in simulation messages.
- LANES, 1: number of serial data wires (1..DATA_W).
- DATA_W, `PAYLOAD_SIZE+`ADDR_BITS: word width.
- DEPTH, 2: output buffer entries (power of two, ≥2).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- serial_in  input  LANES  serial lanes; bit 0 is also the start lane.
- channel_busy  output  1  back-pressure to upstream tx.
- valid  output  1  buffer head holds a word.
- item_read  input  1  consumer pops the head word.
- parallel_out  output  DATA_W  buffer head word.
- overflow  output  1  sticky flag: a frame completed with no free entry.
- rx_active  output  1  high while a frame is being received.

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE; buffer empty.
  - valid=0, parallel_out=0, channel_busy=0, overflow=0, rx_active=0.
- Frame format:
  - Start beat: serial_in[0]=1 while in IDLE.
  - Then BEATS = ceil(DATA_W/LANES) data beats, one per clk.
  - Beat k lane j carries word bit k*LANES+j, so lowest bits arrive first.
  - Bits beyond DATA_W-1 in the last beat are ignored.
- FSM:
  - IDLE: on serial_in[0]=1, go to DATA with beat counter=0. Other lanes in IDLE are don't-care.
  - DATA: shift in one beat per cycle. On counter=BEATS-1, push the assembled word and return to IDLE.
  - Back-to-back frames are allowed: a start bit is accepted on the cycle immediately after the last beat.
- rx_active is high in DATA.
- Latency: start sampled at edge 0, last beat at edge BEATS; valid=1 and parallel_out=word after edge BEATS.
- Buffer:
  - FIFO; valid = not empty; parallel_out = head, registered; holds 0 when empty.
  - item_read with valid=1 pops at the edge. item_read with valid=0 is ignored.
  - Simultaneous push and pop at any occupancy, including full, is legal: count unchanged, order preserved.
- channel_busy = (count + rx_active) >= DEPTH, computed combinationally from registered state. Upstream may start a frame only when channel_busy=0, so every announced frame has a reserved slot.
- Overflow:
  - Applies when a frame completes with the buffer full and no same-cycle pop (protocol violation).
  - The word is dropped and buffer contents are untouched.
  - overflow is set and stays set until reset.
  - Simulation builds $display ID, DIR and the dropped word.
- Reset mid-frame: the partial word is discarded and the FSM returns to IDLE; no push occurs.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: NRX_PARITY_EN.
- When defined:
  - One extra beat follows the data beats; serial_in[0] carries even parity over the DATA_W data bits. Other lanes are ignored.
  - Push happens on the parity beat if parity matches; latency becomes BEATS+1.
  - On mismatch the word is dropped and output parity_err (1 bit) pulses high for one cycle.
  - rx_active covers the parity beat.
- When undefined: no parity beat and no parity_err port.

Test Plan:
- Bench config: LANES=4, DATA_W=16, DEPTH=4.
- Single frame: start, then beats 0x4,0x3,0x2,0x1 → valid rises after edge 4, parallel_out=0x1234; pulse item_read → valid=0, parallel_out=0.
- Back-to-back fill: 4 frames 0x0001..0x0004, no reads → channel_busy=1 from the start of the 4th frame; outputs pop in order 0x0001..0x0004; overflow=0.
- Full with simultaneous pop: buffer holds 3 words, 4th frame completes on the same edge as item_read → count stays 3, no overflow, order preserved.
- Protocol violation: buffer full, force a 5th frame → overflow=1 and sticky; head still 0x0001 and contents unchanged.
- Reset mid-frame: reset=0 after beat 2 → valid=0, rx_active=0, channel_busy=0 immediately (async). After release, a new frame 0xBEEF is received correctly.
- LANES=1, DATA_W=16: frame 0xA5C3 → valid after edge 16 with the exact word. With NRX_PARITY_EN, a wrong parity bit → parity_err one-cycle pulse, valid stays 0.
